pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 81 ++++++++
 tb/tb_pc_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequences fetch addresses through IDLE/RUN/DONE,
// handles jumps, conditional branches, halt, ALU status flags and a cycle count.
module pc_unit #(
  parameter int unsigned     PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic            Jen,
  input  logic            BrEn,
  input  logic            Brc_J,
  input  logic [PC_W-1:0] Target,
  input  logic            SCo,
  input  logic            Zero,
  input  logic            Par,
  input  logic            FlagWe,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Run,
  output logic            Done,
  output logic            CarryF,
  output logic            ZeroF,
  output logic            ParF,
  output logic [15:0]     CycleCnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic        take_branch;
  logic [15:0] cnt_next;

  // Brc_J is active-low "condition true", only meaningful on a branch instruction
  assign take_branch = BrEn && !Brc_J;
  assign cnt_next    = (CycleCnt == 16'hFFFF) ? CycleCnt : CycleCnt + 16'd1;

  assign Run  = (state == RUN);
  assign Done = (state == DONE);

  // Start always wins: from any non-reset state it reinitialises and enters RUN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ProgCtr  <= START_ADDR;
      CycleCnt <= '0;
      CarryF   <= 1'b0;
      ZeroF    <= 1'b0;
      ParF     <= 1'b0;
    end else if (Start) begin
      state    <= RUN;
      ProgCtr  <= START_ADDR;
      CycleCnt <= '0;
      CarryF   <= 1'b0;
      ZeroF    <= 1'b0;
      ParF     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          CycleCnt <= cnt_next;
          if (FlagWe) begin
            CarryF <= SCo;
            ZeroF  <= Zero;
            ParF   <= Par;
          end
          if (Halt)
            state <= DONE;
          else if (Jen || take_branch)
            ProgCtr <= Target;
          else
            ProgCtr <= ProgCtr + 1'b1;
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  logic       Clk, Reset, Start, Halt, Jen, BrEn, Brc_J;
  logic [9:0] Target;
  logic       SCo, Zero, Par, FlagWe;
  logic [9:0] ProgCtr;
  logic       Run, Done, CarryF, ZeroF, ParF;
  logic [15:0] CycleCnt;

  int errors = 0;
  int checks = 0;

  pc_unit #(.PC_W(10), .START_ADDR(10'd0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Jen(Jen),
    .BrEn(BrEn), .Brc_J(Brc_J), .Target(Target), .SCo(SCo), .Zero(Zero),
    .Par(Par), .FlagWe(FlagWe), .ProgCtr(ProgCtr), .Run(Run), .Done(Done),
    .CarryF(CarryF), .ZeroF(ZeroF), .ParF(ParF), .CycleCnt(CycleCnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them
  task automatic applyStimulus(input logic st, input logic hl, input logic jn,
                               input logic be, input logic bc, input logic [9:0] tg,
                               input logic fw, input logic c, input logic z, input logic p);
    Start = st; Halt = hl; Jen = jn; BrEn = be; Brc_J = bc; Target = tg;
    FlagWe = fw; SCo = c; Zero = z; Par = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic stepPlain();
    applyStimulus(0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
  endtask

  task automatic checkFlags(input string tag, input logic [2:0] exp);
    checkOutput(tag, {29'd0, CarryF, ZeroF, ParF}, {29'd0, exp});
  endtask

  initial begin
    Reset = 1'b1;
    Start = 0; Halt = 0; Jen = 0; BrEn = 0; Brc_J = 0; Target = '0;
    FlagWe = 0; SCo = 0; Zero = 0; Par = 0;
    #3;
    checkOutput("rst_pc", ProgCtr, 0);
    checkOutput("rst_run", Run, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_cnt", CycleCnt, 0);
    checkFlags("rst_flags", 3'b000);

    stepPlain();
    stepPlain();
    Reset = 1'b0;

    // IDLE ignores everything but Start
    applyStimulus(0, 0, 1, 0, 0, 10'h055, 1, 1, 1, 1);
    applyStimulus(0, 1, 1, 1, 0, 10'h055, 1, 1, 1, 1);
    checkOutput("idle_run", Run, 0);
    checkOutput("idle_pc", ProgCtr, 0);
    checkFlags("idle_flags", 3'b000);

    applyStimulus(1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    checkOutput("start_run", Run, 1);
    checkOutput("start_pc", ProgCtr, 0);
    checkOutput("start_cnt", CycleCnt, 0);

    for (int i = 1; i <= 5; i++) begin
      stepPlain();
      checkOutput("seq_pc", ProgCtr, i);
    end
    checkOutput("seq_cnt", CycleCnt, 5);
    checkOutput("seq_run", Run, 1);

    stepPlain();
    stepPlain();
    checkOutput("pc7", ProgCtr, 7);
    applyStimulus(0, 0, 1, 0, 0, 10'h040, 0, 0, 0, 0);
    checkOutput("jump", ProgCtr, 10'h040);
    applyStimulus(0, 0, 0, 1, 1, 10'h123, 0, 0, 0, 0);
    checkOutput("br_not_taken", ProgCtr, 10'h041);
    applyStimulus(0, 0, 0, 1, 0, 10'h003, 0, 0, 0, 0);
    checkOutput("br_taken", ProgCtr, 10'h003);
    stepPlain();
    checkOutput("after_br", ProgCtr, 10'h004);
    applyStimulus(0, 0, 0, 0, 0, 10'h200, 0, 0, 0, 0);
    checkOutput("brc_ignored", ProgCtr, 10'h005);
    checkOutput("cnt12", CycleCnt, 12);

    applyStimulus(0, 0, 0, 0, 0, 10'h000, 1, 0, 1, 0);
    checkFlags("flag_latch", 3'b010);
    checkOutput("flag_pc", ProgCtr, 6);
    stepPlain();
    checkFlags("flag_hold", 3'b010);

    for (int i = 0; i < 5; i++) stepPlain();
    checkOutput("pc12", ProgCtr, 12);
    checkOutput("cnt19", CycleCnt, 19);

    // Halt outranks a simultaneous jump; flags still latch in the halt cycle
    applyStimulus(0, 1, 1, 0, 0, 10'h100, 1, 1, 0, 1);
    checkOutput("halt_done", Done, 1);
    checkOutput("halt_run", Run, 0);
    checkOutput("halt_pc", ProgCtr, 12);
    checkFlags("halt_flags", 3'b101);
    checkOutput("halt_cnt", CycleCnt, 20);

    applyStimulus(0, 0, 1, 1, 0, 10'h100, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0, 10'h100, 1, 0, 1, 0);
    checkOutput("done_pc", ProgCtr, 12);
    checkOutput("done_cnt", CycleCnt, 20);
    checkFlags("done_flags", 3'b101);
    checkOutput("done_hold", Done, 1);

    applyStimulus(1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    checkOutput("restart_run", Run, 1);
    checkOutput("restart_done", Done, 0);
    checkOutput("restart_pc", ProgCtr, 0);
    checkOutput("restart_cnt", CycleCnt, 0);
    checkFlags("restart_flags", 3'b000);

    for (int i = 0; i < 1023; i++) stepPlain();
    checkOutput("pc_max", ProgCtr, 10'h3FF);
    stepPlain();
    checkOutput("wrap_pc", ProgCtr, 10'h000);
    checkOutput("wrap_run", Run, 1);
    checkOutput("wrap_cnt", CycleCnt, 1024);

    applyStimulus(0, 0, 0, 0, 0, 10'h000, 1, 1, 1, 1);
    checkFlags("pre_start_flags", 3'b111);
    applyStimulus(1, 1, 1, 1, 0, 10'h2AA, 1, 1, 1, 1);
    checkOutput("prio_pc", ProgCtr, 0);
    checkOutput("prio_run", Run, 1);
    checkOutput("prio_cnt", CycleCnt, 0);
    checkFlags("prio_flags", 3'b000);

    for (int i = 0; i < 20; i++) stepPlain();
    checkOutput("pc20", ProgCtr, 20);
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("async_pc", ProgCtr, 0);
    checkOutput("async_run", Run, 0);
    checkOutput("async_done", Done, 0);
    checkOutput("async_cnt", CycleCnt, 0);
    stepPlain();
    Reset = 1'b0;
    stepPlain();
    stepPlain();
    checkOutput("post_rst_pc", ProgCtr, 0);
    checkOutput("post_rst_run", Run, 0);
    applyStimulus(1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
    stepPlain();
    checkOutput("post_rst_advance", ProgCtr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
